gcd_driver: RTL and testbench

- Initiator side of the gcd start/rdy handshake.
- Accepts operand pairs on an upstream valid/ready stream and drives one gcd_rtl instance through start/xi/yi.
- Waits for rdy, captures xo, and returns the result on a downstream valid/ready stream.
- Adds a zero-operand bypass, a rdy timeout, and a completed-transaction counter. Sits between a command source and gcd_rtl.

---
 rtl/gcd_driver.sv | 193 +++++++++++++++++++
 tb/tb_gcd_driver.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_driver.sv
// gcd_driver: initiator side of the gcd_rtl start/rdy handshake.
//
// Operand pairs arrive on an upstream valid/ready stream. Each pair is
// issued to one gcd_rtl engine through gcd_start/gcd_xi/gcd_yi. The block
// then waits for gcd_rdy, captures gcd_xo and returns the result on a
// downstream valid/ready stream. Only one transaction is in flight at a time.
// A pair with a zero operand bypasses the engine. An engine that stays silent
// too long produces an error result. done_cnt counts delivered results.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  upstream handshake; in_x/in_y are unsigned operands
//   out_valid/out_ready downstream handshake; out_gcd result,
//                      out_err marks a timeout abort
//   gcd_xi/gcd_yi      operands to gcd_rtl, held stable while in flight
//   gcd_start          start pulse to gcd_rtl
//   gcd_xo/gcd_rdy     result and ready from gcd_rtl
//   busy               transaction in progress (state != IDLE)
//   done_cnt           results delivered, wraps
module gcd_driver #(
  parameter int NBits   = 16,
  parameter int TIMEOUT = 1024,
  parameter int CNTW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBits-1:0] in_x,
  input  logic [NBits-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBits-1:0] out_gcd,
  output logic             out_err,
  output logic [NBits-1:0] gcd_xi,
  output logic [NBits-1:0] gcd_yi,
  output logic             gcd_start,
  input  logic [NBits-1:0] gcd_xo,
  input  logic             gcd_rdy,
  output logic             busy,
  output logic [CNTW-1:0]  done_cnt
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [NBits-1:0] op_x, op_x_nxt;
  logic [NBits-1:0] op_y, op_y_nxt;
  logic [NBits-1:0] gcd_q, gcd_nxt;
  logic             err_q, err_nxt;
  logic             valid_q, valid_nxt;
  logic [CNTW-1:0]  cnt_q, cnt_nxt;
  logic [TW-1:0]    tcnt, tcnt_nxt;
  logic             expire;

  // The counter is cleared on the acceptance edge and steps on every
  // in-flight edge. Comparing against TIMEOUT-2 lets the abort take effect
  // on the same edge that moves the count to TIMEOUT-1. The result therefore
  // shows up TIMEOUT-1 edges after acceptance.
  assign expire = (tcnt == TW'(TIMEOUT - 2));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      op_x    <= '0;
      op_y    <= '0;
      gcd_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      tcnt    <= '0;
    end else begin
      state   <= state_nxt;
      op_x    <= op_x_nxt;
      op_y    <= op_y_nxt;
      gcd_q   <= gcd_nxt;
      err_q   <= err_nxt;
      valid_q <= valid_nxt;
      cnt_q   <= cnt_nxt;
      tcnt    <= tcnt_nxt;
    end
  end

  // Next-state, next-register values and the start pulse.
  always_comb begin
    state_nxt = state;
    op_x_nxt  = op_x;
    op_y_nxt  = op_y;
    gcd_nxt   = gcd_q;
    err_nxt   = err_q;
    valid_nxt = valid_q;
    cnt_nxt   = cnt_q;
    tcnt_nxt  = tcnt;
    gcd_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          op_x_nxt = in_x;
          op_y_nxt = in_y;
          tcnt_nxt = '0;
          if ((in_x == '0) || (in_y == '0)) begin
            // Bypass: gcd(a,0)=a, and gcd(0,0) is reported as 0.
            state_nxt = S_HOLD;
            gcd_nxt   = in_x | in_y;
            err_nxt   = 1'b0;
            valid_nxt = 1'b1;
          end else begin
            state_nxt = S_ISSUE;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        // Start only when the engine reports ready. A busy engine, such as
        // one left running across a reset, is simply waited on.
        gcd_start = gcd_rdy;
        tcnt_nxt  = tcnt + TW'(1);
        if (expire) begin
          state_nxt = S_HOLD;
          gcd_nxt   = '0;
          err_nxt   = 1'b1;
          valid_nxt = 1'b1;
        end else if (gcd_rdy) begin
          state_nxt = S_SETTLE;
        end else begin
          state_nxt = S_ISSUE;
        end
      end
      S_SETTLE: begin
        // The engine drops rdy during this cycle, so rdy is not looked at.
        tcnt_nxt = tcnt + TW'(1);
        if (expire) begin
          state_nxt = S_HOLD;
          gcd_nxt   = '0;
          err_nxt   = 1'b1;
          valid_nxt = 1'b1;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        tcnt_nxt = tcnt + TW'(1);
        if (gcd_rdy) begin
          // A capture wins over a timeout that lands in the same cycle.
          state_nxt = S_HOLD;
          gcd_nxt   = gcd_xo;
          err_nxt   = 1'b0;
          valid_nxt = 1'b1;
        end else if (expire) begin
          state_nxt = S_HOLD;
          gcd_nxt   = '0;
          err_nxt   = 1'b1;
          valid_nxt = 1'b1;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
          valid_nxt = 1'b0;
          cnt_nxt   = cnt_q + CNTW'(1);
        end else begin
          state_nxt = S_HOLD;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = valid_q;
  assign out_gcd   = gcd_q;
  assign out_err   = err_q;
  assign done_cnt  = cnt_q;
  assign gcd_xi    = op_x;
  assign gcd_yi    = op_y;

endmodule

// File: tb/tb_gcd_driver.sv
// Self-checking bench for gcd_driver. A behavioural gcd engine serves the
// main instance. A second instance with TIMEOUT=16 has its engine ready
// held low. Expected results go to a scoreboard queue when operands are
// driven, and are popped on each downstream handshake.
module tb_gcd_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [15:0] in_x, in_y, out_gcd, gcd_xi, gcd_yi, gcd_xo;
  logic        gcd_start, gcd_rdy, busy;
  logic [15:0] done_cnt;

  logic        t_in_valid, t_in_ready, t_out_valid, t_out_ready, t_out_err;
  logic [15:0] t_x, t_y, t_out_gcd, t_xi, t_yi;
  logic [15:0] t_xo;
  logic        t_rdy, t_start, t_busy;
  logic [15:0] t_done_cnt;

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_hs = 0;
  logic [15:0] cur_x = 16'd0;
  logic [15:0] cur_y = 16'd0;
  logic [16:0] exp_q[$];

  // Behavioural engine.
  logic        eng_rdy = 1'b1;
  logic [15:0] ea = 16'd0;
  logic [15:0] eb = 16'd0;
  logic [15:0] eng_xo = 16'd0;
  int          edly = 0;

  always #5 clk = ~clk;

  gcd_driver #(.NBits(16), .TIMEOUT(1024), .CNTW(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready),
    .out_gcd(out_gcd), .out_err(out_err), .gcd_xi(gcd_xi), .gcd_yi(gcd_yi),
    .gcd_start(gcd_start), .gcd_xo(gcd_xo), .gcd_rdy(gcd_rdy), .busy(busy),
    .done_cnt(done_cnt)
  );

  gcd_driver #(.NBits(16), .TIMEOUT(16), .CNTW(16)) u_dut_to (
    .clk(clk), .rst(rst), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .in_x(t_x), .in_y(t_y), .out_valid(t_out_valid), .out_ready(t_out_ready),
    .out_gcd(t_out_gcd), .out_err(t_out_err), .gcd_xi(t_xi), .gcd_yi(t_yi),
    .gcd_start(t_start), .gcd_xo(t_xo), .gcd_rdy(t_rdy), .busy(t_busy),
    .done_cnt(t_done_cnt)
  );

  assign gcd_rdy = eng_rdy;
  assign gcd_xo  = eng_rdy ? eng_xo : 16'hDEAD;
  assign t_rdy   = 1'b0;
  assign t_xo    = 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_gcd(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] a, b;
    a = x;
    b = y;
    if (a == 16'd0) return b;
    if (b == 16'd0) return a;
    while (a != b) begin
      if (a > b) a = a - b;
      else b = b - a;
    end
    return a;
  endfunction

  // Engine: Euclid by remainder, plus a few extra busy cycles.
  always @(posedge clk) begin
    if (eng_rdy) begin
      if (gcd_start) begin
        ea      <= gcd_xi;
        eb      <= gcd_yi;
        edly    <= 4;
        eng_rdy <= 1'b0;
      end
    end else if (eb != 16'd0) begin
      ea <= eb;
      eb <= ea % eb;
    end else if (edly > 0) begin
      edly <= edly - 1;
    end else begin
      eng_xo  <= ea;
      eng_rdy <= 1'b1;
    end
  end

  // Monitor on the falling edge: scoreboard pops, start counting, operand stability.
  always @(negedge clk) begin
    if (rst) begin
      if (gcd_start) n_start++;
      if (busy) begin
        check("xi_stable", gcd_xi, cur_x);
        check("yi_stable", gcd_yi, cur_y);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", 32'd1, 32'd0);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          check("out_gcd", out_gcd, e[15:0]);
          check("out_err", out_err, e[16]);
        end
        n_hs++;
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y);
    int n;
    n = 0;
    while (!in_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    cur_x = x;
    cur_y = y;
    exp_q.push_back({1'b0, ref_gcd(x, y)});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    int s0, n;
    rst = 1'b0;
    in_valid = 1'b0; in_x = 16'd0; in_y = 16'd0; out_ready = 1'b1;
    t_in_valid = 1'b0; t_x = 16'd0; t_y = 16'd0; t_out_ready = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done_cnt", done_cnt, 0);
    check("rst_out_gcd", out_gcd, 0);
    check("rst_out_err", out_err, 0);
    check("rst_start", gcd_start, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Normal transaction.
    s0 = n_start;
    send(16'd48, 16'd18);
    wait_idle();
    check("t1_starts", n_start - s0, 1);
    check("t1_done_cnt", done_cnt, n_hs);

    // Back-to-back.
    send(16'd17, 16'd13);
    check("t2_in_ready_busy", in_ready, 0);
    send(16'hFFFF, 16'h00FF);
    wait_idle();
    check("t2_done_cnt", done_cnt, n_hs);

    // Zero-operand bypass: out_valid one cycle after acceptance.
    s0 = n_start;
    send(16'd0, 16'd25);
    check("byp1_valid", out_valid, 1);
    check("byp1_gcd", out_gcd, 25);
    @(posedge clk); #1;
    send(16'd0, 16'd0);
    check("byp2_valid", out_valid, 1);
    check("byp2_gcd", out_gcd, 0);
    wait_idle();
    check("byp_starts", n_start - s0, 0);

    // Downstream backpressure.
    out_ready = 1'b0;
    send(16'd48, 16'd18);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_valid_seen", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_gcd", out_gcd, 6);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    s0 = n_hs;
    out_ready = 1'b1;
    wait_idle();
    check("hold_once", n_hs - s0, 1);
    check("hold_done_cnt", done_cnt, n_hs);

    // Timeout on the TIMEOUT=16 instance with a silent engine.
    t_in_valid = 1'b1; t_x = 16'd5; t_y = 16'd7;
    @(posedge clk); #1;
    t_in_valid = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      check("to_no_start", t_start, 0);
      if (k == 14) check("to_not_yet", t_out_valid, 0);
    end
    check("to_valid", t_out_valid, 1);
    check("to_gcd", t_out_gcd, 0);
    check("to_err", t_out_err, 1);
    t_out_ready = 1'b1;
    @(posedge clk); #1;
    check("to_done_cnt", t_done_cnt, 1);
    check("to_valid_drop", t_out_valid, 0);

    // Reset during WAIT.
    send(16'd100, 16'd75);
    n = 0;
    while (eng_rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    check("mid_busy", busy, 1);
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_start", gcd_start, 0);
    check("mid_rst_done_cnt", done_cnt, 0);
    check("mid_rst_xi", gcd_xi, 0);
    exp_q.delete();
    n_hs = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    send(16'd100, 16'd75);
    wait_idle();
    check("mid_done_cnt", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog got=1 want=0");
    $fatal(1, "watchdog");
  end

endmodule
